// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM client port: handshake helper, byte-strobe codes, FSM states.
package sdram_pkg;

  typedef enum logic [0:0] {StIdle, StWait} sdram_state_e;

  localparam logic [1:0] DS_WORD = 2'b11;
  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;

  // Toggle handshake: the transfer is finished once ack has caught up with req.
  function automatic logic ack_match(input logic req, input logic ack);
    return req == ack;
  endfunction

endpackage

// File: rtl/sdram_cpu_port_if.sv
// Toggle-handshake SDRAM port as seen by one client of the SDRAM controller.
interface sdram_cpu_port_if;
  logic        req;
  logic        ack;
  logic        we;
  logic [23:0] a;
  logic [1:0]  ds;
  logic [15:0] d;
  logic [15:0] q;

  modport master (output req, we, a, ds, d, input ack, q);
  modport slave  (input req, we, a, ds, d, output ack, q);
endinterface

// File: rtl/sdram_rdbuf.sv
// One-word read buffer: tag/data/valid storage, hit compare and byte write-merge.
module sdram_rdbuf (
  input  logic        clk,
  input  logic        init_n,
  input  logic [23:0] look_a,
  output logic        hit,
  output logic [15:0] rd_data,
  input  logic        load,
  input  logic [23:0] load_a,
  input  logic [15:0] load_d,
  input  logic        wr_en,
  input  logic [24:0] wr_a,
  input  logic [7:0]  wr_byte
);

  logic        valid_q;
  logic [23:0] tag_q;
  logic [15:0] data_q;
  logic        wr_hit;

  assign hit     = valid_q && (tag_q == look_a);
  assign rd_data = data_q;
  assign wr_hit  = wr_en && valid_q && (tag_q == wr_a[24:1]);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      tag_q   <= load_a;
      data_q  <= load_d;
    end else if (wr_hit) begin
      // Keep the buffer coherent with writes instead of invalidating it.
      if (wr_a[0]) data_q[15:8] <= wr_byte;
      else         data_q[7:0]  <= wr_byte;
    end
  end

endmodule

// File: rtl/sdram_cpu_port.sv
// Bridges CPU byte cycles and a byte-serial download stream onto one toggle-handshake SDRAM port.
module sdram_cpu_port
  import sdram_pkg::*;
#(
  parameter bit RDBUF_EN = 1'b1,
  parameter bit DL_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [24:0] cpu_a,
  input  logic [7:0]  cpu_d,
  output logic [7:0]  cpu_q,
  output logic        cpu_busy,
  input  logic        dl_wr,
  input  logic [24:0] dl_a,
  input  logic [7:0]  dl_d,
  output logic        dl_busy,
  sdram_cpu_port_if.master sdram
);

  sdram_state_e state_q, state_d;

  logic        cpu_pend_q, cpu_wr_q;
  logic [24:0] cpu_a_q;
  logic [7:0]  cpu_d_q;
  logic        dl_pend_q;
  logic [24:0] dl_a_q;
  logic [7:0]  dl_d_q;
  logic        req_q, we_q;
  logic [23:0] a_q;
  logic [1:0]  ds_q;
  logic [15:0] d_q;
  logic        srv_dl_q, srv_a0_q;
  logic [7:0]  cpu_q_q;

  logic        buf_hit, rd_hit, cpu_acc, dl_acc, any_pend;
  logic        cpu_ready, dl_ready;
  logic        issue, pick_dl, done, sel_we;
  logic [24:0] sel_a;
  logic [7:0]  sel_d;
  logic [15:0] buf_data;

  assign rd_hit   = RDBUF_EN && cpu_rd && !cpu_wr && buf_hit && !cpu_pend_q;
  assign cpu_acc  = (cpu_rd || cpu_wr) && !cpu_pend_q && !rd_hit;
  assign dl_acc   = dl_wr && !dl_pend_q;
  assign any_pend = cpu_pend_q || dl_pend_q;
  // A fresh strobe may bypass the pending register only when nothing else is queued.
  assign cpu_ready = cpu_pend_q || (cpu_acc && !any_pend);
  assign dl_ready  = dl_pend_q || (dl_acc && !any_pend);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cpu_ready || dl_ready) state_d = StWait;
      StWait: if (ack_match(req_q, sdram.ack)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue   = (state_q == StIdle) && (cpu_ready || dl_ready);
    done    = (state_q == StWait) && ack_match(req_q, sdram.ack);
    pick_dl = dl_ready && (DL_FIRST || !cpu_ready);
    if (pick_dl) begin
      sel_a  = dl_pend_q ? dl_a_q : dl_a;
      sel_d  = dl_pend_q ? dl_d_q : dl_d;
      sel_we = 1'b1;
    end else begin
      sel_a  = cpu_pend_q ? cpu_a_q : cpu_a;
      sel_d  = cpu_pend_q ? cpu_d_q : cpu_d;
      sel_we = cpu_pend_q ? cpu_wr_q : cpu_wr;
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      cpu_pend_q <= 1'b0;
      cpu_wr_q   <= 1'b0;
      cpu_a_q    <= '0;
      cpu_d_q    <= '0;
      dl_pend_q  <= 1'b0;
      dl_a_q     <= '0;
      dl_d_q     <= '0;
    end else begin
      if (cpu_acc) begin
        cpu_pend_q <= 1'b1;
        cpu_wr_q   <= cpu_wr;
        cpu_a_q    <= cpu_a;
        cpu_d_q    <= cpu_d;
      end else if (done && !srv_dl_q) begin
        cpu_pend_q <= 1'b0;
      end
      if (dl_acc) begin
        dl_pend_q <= 1'b1;
        dl_a_q    <= dl_a;
        dl_d_q    <= dl_d;
      end else if (done && srv_dl_q) begin
        dl_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      a_q      <= '0;
      ds_q     <= '0;
      d_q      <= '0;
      srv_dl_q <= 1'b0;
      srv_a0_q <= 1'b0;
      cpu_q_q  <= '0;
    end else begin
      if (issue) begin
        req_q    <= ~req_q;
        we_q     <= sel_we;
        a_q      <= sel_a[24:1];
        ds_q     <= sel_we ? (sel_a[0] ? DS_HI : DS_LO) : DS_WORD;
        if (sel_we) d_q <= {sel_d, sel_d};
        srv_dl_q <= pick_dl;
        srv_a0_q <= sel_a[0];
      end
      if (rd_hit) begin
        cpu_q_q <= cpu_a[0] ? buf_data[15:8] : buf_data[7:0];
      end else if (done && !we_q) begin
        cpu_q_q <= srv_a0_q ? sdram.q[15:8] : sdram.q[7:0];
      end
    end
  end

  sdram_rdbuf u_rdbuf (
    .clk     (clk),
    .init_n  (init_n),
    .look_a  (cpu_a[24:1]),
    .hit     (buf_hit),
    .rd_data (buf_data),
    .load    (done && !we_q),
    .load_a  (a_q),
    .load_d  (sdram.q),
    .wr_en   (issue && sel_we),
    .wr_a    (sel_a),
    .wr_byte (sel_d)
  );

  assign sdram.req = req_q;
  assign sdram.we  = we_q;
  assign sdram.a   = a_q;
  assign sdram.ds  = ds_q;
  assign sdram.d   = d_q;
  assign cpu_q     = cpu_q_q;
  assign cpu_busy  = cpu_pend_q;
  assign dl_busy   = dl_pend_q;

endmodule

// File: tb/tb_sdram_cpu_port.sv
// Directed bench for sdram_cpu_port with a latency-programmable toggle-handshake SDRAM model.
module tb_sdram_cpu_port;

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0, dl_wr = 1'b0;
  logic [24:0] cpu_a = '0, dl_a = '0;
  logic [7:0]  cpu_d = '0, dl_d = '0;
  logic [7:0]  cpu_q;
  logic        cpu_busy, dl_busy;

  int n_total = 0;
  int n_pass  = 0;
  int lat     = 6;
  int toggles = 0;
  int cnt     = 0;
  logic m_busy;
  logic [15:0] mem [0:255];
  bit          mem_vld [0:255];

  always #5 clk = ~clk;

  sdram_cpu_port_if sdram_bus ();

  sdram_cpu_port #(
    .RDBUF_EN (1'b1),
    .DL_FIRST (1'b1)
  ) dut (
    .clk      (clk),
    .init_n   (init_n),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_a    (cpu_a),
    .cpu_d    (cpu_d),
    .cpu_q    (cpu_q),
    .cpu_busy (cpu_busy),
    .dl_wr    (dl_wr),
    .dl_a     (dl_a),
    .dl_d     (dl_d),
    .dl_busy  (dl_busy),
    .sdram    (sdram_bus.master)
  );

  function automatic logic [15:0] pattern(input logic [23:0] a);
    if (a == 24'h8) return 16'hBEEF;
    return {a[7:0], ~a[7:0]};
  endfunction

  function automatic logic [15:0] rd_word(input logic [23:0] a);
    if (mem_vld[a[7:0]]) return mem[a[7:0]];
    return pattern(a);
  endfunction

  // SDRAM model: acknowledges each toggle after lat cycles; memory survives reset.
  always @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      sdram_bus.ack <= 1'b0;
      sdram_bus.q   <= '0;
      m_busy        <= 1'b0;
      cnt           <= 0;
    end else if (!m_busy) begin
      if (sdram_bus.req != sdram_bus.ack) begin
        m_busy  <= 1'b1;
        cnt     <= lat;
        toggles <= toggles + 1;
      end
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end else begin
      m_busy        <= 1'b0;
      sdram_bus.ack <= sdram_bus.req;
      if (sdram_bus.we) begin
        mem[sdram_bus.a[7:0]] <= {sdram_bus.ds[1] ? sdram_bus.d[15:8] : rd_word(sdram_bus.a)[15:8],
                                  sdram_bus.ds[0] ? sdram_bus.d[7:0] : rd_word(sdram_bus.a)[7:0]};
        mem_vld[sdram_bus.a[7:0]] <= 1'b1;
      end else begin
        sdram_bus.q <= rd_word(sdram_bus.a);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic rd, input logic wr, input logic [24:0] a, input logic [7:0] d);
    cpu_rd = rd;
    cpu_wr = wr;
    cpu_a  = a;
    cpu_d  = d;
    tick();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((cpu_busy || dl_busy) && n < 200) begin
      tick();
      n++;
    end
    check_eq({tag, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  initial begin
    int t0, n, bad;
    logic [23:0] cap_a;
    logic [1:0]  cap_ds;
    logic [15:0] cap_d;
    logic        cap_we;
    logic        busy_seen;

    repeat (3) tick();
    check_eq("rst_req", 32'(sdram_bus.req), 32'd0);
    check_eq("rst_a_ds_d_we", {sdram_bus.a[7:0], 2'b0, sdram_bus.ds, sdram_bus.d, 3'b0, sdram_bus.we}, 32'd0);
    check_eq("rst_cpu", {22'd0, cpu_busy, dl_busy, cpu_q}, 32'd0);
    init_n = 1'b1;
    tick();

    // Read miss at 0x10: one word read, low byte returned.
    lat = 6;
    t0 = toggles;
    strobe(1'b1, 1'b0, 25'h10, 8'h0);
    check_eq("miss_req_toggled", 32'(sdram_bus.req ^ sdram_bus.ack), 32'd1);
    check_eq("miss_ds", 32'(sdram_bus.ds), 32'd3);
    check_eq("miss_we", 32'(sdram_bus.we), 32'd0);
    check_eq("miss_a", 32'(sdram_bus.a), 32'h8);
    check_eq("miss_busy", 32'(cpu_busy), 32'd1);
    wait_idle("miss");
    check_eq("miss_toggles", 32'(toggles - t0), 32'd1);
    check_eq("miss_q", 32'(cpu_q), 32'hEF);

    // Buffer hit on the odd byte of the same word.
    t0 = toggles;
    strobe(1'b1, 1'b0, 25'h11, 8'h0);
    check_eq("hit_q", 32'(cpu_q), 32'hBE);
    busy_seen = cpu_busy;
    repeat (3) begin
      tick();
      busy_seen = busy_seen | cpu_busy;
    end
    check_eq("hit_busy", 32'(busy_seen), 32'd0);
    check_eq("hit_toggles", 32'(toggles - t0), 32'd0);

    // Odd-byte write.
    t0 = toggles;
    strobe(1'b0, 1'b1, 25'h21, 8'h5A);
    check_eq("wr_we", 32'(sdram_bus.we), 32'd1);
    check_eq("wr_a", 32'(sdram_bus.a), 32'h10);
    check_eq("wr_ds", 32'(sdram_bus.ds), 32'd2);
    check_eq("wr_d", 32'(sdram_bus.d), 32'h5A5A);
    n = 0;
    while (sdram_bus.ack !== sdram_bus.req && n < 200) begin
      tick();
      n++;
    end
    check_eq("wr_ack_timeout", 32'(n < 200), 32'd1);
    check_eq("wr_busy_at_ack", 32'(cpu_busy), 32'd1);
    tick();
    check_eq("wr_busy_after", 32'(cpu_busy), 32'd0);
    check_eq("wr_toggles", 32'(toggles - t0), 32'd1);

    // Write into the buffered word, then read it back from the buffer.
    t0 = toggles;
    strobe(1'b0, 1'b1, 25'h10, 8'h12);
    wait_idle("merge_wr");
    check_eq("merge_wr_toggles", 32'(toggles - t0), 32'd1);
    t0 = toggles;
    strobe(1'b1, 1'b0, 25'h10, 8'h0);
    check_eq("merge_q", 32'(cpu_q), 32'h12);
    check_eq("merge_busy", 32'(cpu_busy), 32'd0);
    tick();
    check_eq("merge_toggles", 32'(toggles - t0), 32'd0);

    // Simultaneous download write and CPU read: download goes first.
    lat = 3;
    t0 = toggles;
    dl_wr = 1'b1;
    dl_a  = 25'h100;
    dl_d  = 8'hAA;
    strobe(1'b1, 1'b0, 25'h200, 8'h0);
    dl_wr = 1'b0;
    check_eq("sim_first_we", 32'(sdram_bus.we), 32'd1);
    check_eq("sim_first_a", 32'(sdram_bus.a), 32'h80);
    check_eq("sim_first_ds", 32'(sdram_bus.ds), 32'd1);
    check_eq("sim_first_d", 32'(sdram_bus.d), 32'hAAAA);
    check_eq("sim_both_busy", {30'd0, dl_busy, cpu_busy}, 32'd3);
    n = 0;
    while (dl_busy && n < 200) begin
      tick();
      n++;
    end
    check_eq("sim_dl_timeout", 32'(n < 200), 32'd1);
    check_eq("sim_order", 32'(cpu_busy), 32'd1);
    tick();
    check_eq("sim_second_a", 32'(sdram_bus.a), 32'h100);
    check_eq("sim_second_rd", {30'd0, sdram_bus.we, sdram_bus.ds[0]}, 32'd1);
    wait_idle("sim");
    check_eq("sim_toggles", 32'(toggles - t0), 32'd2);
    check_eq("sim_q", 32'(cpu_q), 32'hFF);

    // Long stall: outputs hold, second read while busy is dropped.
    lat = 20;
    t0 = toggles;
    strobe(1'b1, 1'b0, 25'h400, 8'h0);
    cap_a  = sdram_bus.a;
    cap_ds = sdram_bus.ds;
    cap_d  = sdram_bus.d;
    cap_we = sdram_bus.we;
    bad = 0;
    n = 0;
    while (cpu_busy && n < 200) begin
      if (sdram_bus.a !== cap_a || sdram_bus.ds !== cap_ds ||
          sdram_bus.d !== cap_d || sdram_bus.we !== cap_we) bad++;
      cpu_rd = (n == 4);
      cpu_a  = (n == 4) ? 25'h6A3 : 25'h400;
      tick();
      n++;
    end
    cpu_rd = 1'b0;
    check_eq("stall_timeout", 32'(n < 200), 32'd1);
    check_eq("stall_long", 32'(n > 20), 32'd1);
    check_eq("stall_stable", 32'(bad), 32'd0);
    check_eq("stall_q", 32'(cpu_q), 32'hFF);
    repeat (5) tick();
    check_eq("stall_toggles", 32'(toggles - t0), 32'd1);

    // Reset while waiting for ack.
    lat = 10;
    strobe(1'b1, 1'b0, 25'h50, 8'h0);
    repeat (3) tick();
    check_eq("mid_in_wait", 32'(cpu_busy), 32'd1);
    init_n = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(sdram_bus.req), 32'd0);
    check_eq("mid_rst_a_ds_d_we", {sdram_bus.a[7:0], 2'b0, sdram_bus.ds, sdram_bus.d, 3'b0, sdram_bus.we}, 32'd0);
    check_eq("mid_rst_cpu", {22'd0, cpu_busy, dl_busy, cpu_q}, 32'd0);
    tick();
    init_n = 1'b1;
    tick();
    t0 = toggles;
    strobe(1'b1, 1'b0, 25'h401, 8'h0);
    check_eq("post_rst_miss_busy", 32'(cpu_busy), 32'd1);
    wait_idle("post_rst");
    check_eq("post_rst_toggles", 32'(toggles - t0), 32'd1);
    check_eq("post_rst_q", 32'(cpu_q), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
